// File: rtl/io_port_bank.sv
// Memory-mapped I/O bank: NUM_OUT writable output registers, NUM_IN synchronised inputs with
// sticky change flags and a maskable interrupt. Read data is registered (one cycle latency).
module io_port_bank #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       NUM_OUT   = 3,
   parameter int unsigned       NUM_IN    = 2,
   parameter logic [DATA_W-1:0] OUT_RESET = '0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      sel,
   input  logic                      we,
   input  logic                      rd,
   input  logic [4:0]                addr,
   input  logic [DATA_W-1:0]         wdata,
   output logic [DATA_W-1:0]         rdata,
   output logic                      rvalid,
   input  logic [NUM_IN*DATA_W-1:0]  in_port,
   output logic [NUM_OUT*DATA_W-1:0] out_port,
   output logic                      irq
);

   localparam logic [4:0] ADDR_STATUS = 5'd30;
   localparam logic [4:0] ADDR_IRQ_EN = 5'd31;

   logic [DATA_W-1:0] out_q  [NUM_OUT];
   logic [DATA_W-1:0] s1_q   [NUM_IN];
   logic [DATA_W-1:0] s2_q   [NUM_IN];
   logic [DATA_W-1:0] prev_q [NUM_IN];
   logic [NUM_IN-1:0] status_q, status_d, status_clr, irq_en_q, change_vec;
   logic [1:0]        prime_cnt_q;
   logic              primed;
   logic              wr_en, rd_en;
   logic [DATA_W-1:0] rd_word;

   assign wr_en  = sel && we;
   assign rd_en  = sel && rd;
   assign primed = (prime_cnt_q == 2'd3);

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
      assign out_port[g*DATA_W +: DATA_W] = out_q[g];
   end

   // Priming suppresses spurious flags while the synchroniser fills after reset.
   always_comb begin
      change_vec = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         change_vec[i] = primed && (s2_q[i] != prev_q[i]);
      end
   end

   // Set wins over a simultaneous write-1-to-clear.
   always_comb begin
      status_clr = '0;
      if (wr_en && addr == ADDR_STATUS) status_clr = wdata[NUM_IN-1:0];
      status_d = (status_q & ~status_clr) | change_vec;
   end

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (addr == 5'(i)) rd_word = out_q[i];
      end
      for (int i = 0; i < NUM_IN; i++) begin
         if (addr == 5'(16 + i)) rd_word = s2_q[i];
      end
      if (addr == ADDR_STATUS) rd_word = DATA_W'(status_q);
      if (addr == ADDR_IRQ_EN) rd_word = DATA_W'(irq_en_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_OUT; i++) out_q[i] <= OUT_RESET;
         for (int i = 0; i < NUM_IN; i++) begin
            s1_q[i]   <= '0;
            s2_q[i]   <= '0;
            prev_q[i] <= '0;
         end
         status_q    <= '0;
         irq_en_q    <= '0;
         prime_cnt_q <= '0;
         rdata       <= '0;
         rvalid      <= 1'b0;
         irq         <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_IN; i++) begin
            s1_q[i]   <= in_port[i*DATA_W +: DATA_W];
            s2_q[i]   <= s1_q[i];
            prev_q[i] <= s2_q[i];
         end
         if (wr_en) begin
            for (int i = 0; i < NUM_OUT; i++) begin
               if (addr == 5'(i)) out_q[i] <= wdata;
            end
            if (addr == ADDR_IRQ_EN) irq_en_q <= wdata[NUM_IN-1:0];
         end
         if (!primed) prime_cnt_q <= prime_cnt_q + 2'd1;
         status_q <= status_d;
         irq      <= |(status_q & irq_en_q);
         rvalid   <= rd_en;
         if (rd_en) rdata <= rd_word;
      end
   end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank with default parameters (32-bit, 3 outputs, 2 inputs).
module tb_io_port_bank;

   localparam int DW = 32;
   localparam int NO = 3;
   localparam int NI = 2;

   logic clock = 1'b0;
   logic reset, sel, we, rd;
   logic [4:0]       addr;
   logic [DW-1:0]    wdata, rdata;
   logic             rvalid, irq;
   logic [NI*DW-1:0] in_port;
   logic [NO*DW-1:0] out_port;

   int vectors     = 0;
   int miscompares = 0;

   io_port_bank #(
      .DATA_W   (DW),
      .NUM_OUT  (NO),
      .NUM_IN   (NI),
      .OUT_RESET(32'h0)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .sel     (sel),
      .we      (we),
      .rd      (rd),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .rvalid  (rvalid),
      .in_port (in_port),
      .out_port(out_port),
      .irq     (irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [DW-1:0] d);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      tick();
      sel = 1'b0; we = 1'b0;
   endtask

   task automatic rd_chk(input logic [4:0] a, input logic [DW-1:0] exp, input string tag);
      sel = 1'b1; rd = 1'b1; addr = a;
      tick();
      sel = 1'b0; rd = 1'b0;
      check({tag, "_rvalid"}, 96'(rvalid), 96'(1));
      check(tag, 96'(rdata), 96'(exp));
   endtask

   initial begin
      reset = 1'b1; sel = 1'b0; we = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
      in_port = {32'h0, 32'h5A};

      // 1: reset state, then no spurious flags after the synchroniser fills
      repeat (3) tick();
      check("rst_rvalid", 96'(rvalid), 96'(0));
      check("rst_irq", 96'(irq), 96'(0));
      check("rst_out", 96'(out_port), 96'(0));
      reset = 1'b0;
      repeat (10) tick();
      check("post_rst_irq", 96'(irq), 96'(0));
      rd_chk(5'd30, 32'h0, "post_rst_status");
      rd_chk(5'd16, 32'h5A, "post_rst_in0");
      check("post_rst_out", 96'(out_port), 96'(0));

      // 2: write/read OUT[1]
      wr(5'd1, 32'h12345678);
      check("out1_write", 96'(out_port[63:32]), 96'(32'h12345678));
      rd_chk(5'd1, 32'h12345678, "out1_read");
      tick();
      check("rvalid_drop", 96'(rvalid), 96'(0));
      check("rdata_hold", 96'(rdata), 96'(32'h12345678));

      // 3: change on input 0 with IRQ_EN=1, polling STATUS every cycle
      wr(5'd31, 32'h1);
      in_port[31:0] = 32'hFF;
      sel = 1'b1; rd = 1'b1; addr = 5'd30;
      tick();  // E0
      tick();  // E1
      tick();  // E2: STATUS set here; read sampled the old value
      check("status_e2", 96'(rdata), 96'(0));
      check("irq_e2", 96'(irq), 96'(0));
      tick();  // E3
      check("status_e3", 96'(rdata), 96'(1));
      check("irq_e3", 96'(irq), 96'(1));
      sel = 1'b0; rd = 1'b0;
      rd_chk(5'd16, 32'hFF, "in0_ff");
      wr(5'd30, 32'h1);
      check("irq_hold_clr", 96'(irq), 96'(1));
      rd_chk(5'd30, 32'h0, "status_clr");
      check("irq_clr", 96'(irq), 96'(0));

      // 4: W1C on the same edge a new change sets the flag: set wins
      in_port[31:0] = 32'h11;
      tick();  // E0
      tick();  // E1
      wr(5'd30, 32'h1);  // E2
      rd_chk(5'd30, 32'h1, "set_wins");
      check("set_wins_irq", 96'(irq), 96'(1));
      wr(5'd30, 32'h1);
      rd_chk(5'd30, 32'h0, "status_clr2");

      // 5: writes to IN and unmapped offsets are ignored
      wr(5'd16, 32'hCAFE);
      wr(5'd9, 32'hBEEF);
      rd_chk(5'd16, 32'h11, "in0_ro");
      rd_chk(5'd9, 32'h0, "unmapped9");
      rd_chk(5'd20, 32'h0, "unmapped20");
      check("out_unchanged", 96'(out_port), {32'h0, 32'h12345678, 32'h0});

      // read-before-write on OUT[2]
      sel = 1'b1; we = 1'b1; rd = 1'b1; addr = 5'd2; wdata = 32'h77;
      tick();
      sel = 1'b0; we = 1'b0; rd = 1'b0;
      check("rbw_rdata", 96'(rdata), 96'(0));
      check("rbw_out2", 96'(out_port[95:64]), 96'(32'h77));

      // masked input 1 flags STATUS but not irq; IRQ_EN upper bits read 0
      in_port[63:32] = 32'h1;
      repeat (4) tick();
      check("irq_masked", 96'(irq), 96'(0));
      rd_chk(5'd30, 32'h2, "status_bit1");
      wr(5'd31, 32'hFFFF_FFFF);
      rd_chk(5'd31, 32'h3, "irq_en_width");
      check("irq_unmasked", 96'(irq), 96'(1));

      // 6: reset during a read drops it and clears state
      wr(5'd0, 32'hDEAD);
      check("out0_dead", 96'(out_port[31:0]), 96'(32'hDEAD));
      reset = 1'b1; sel = 1'b1; rd = 1'b1; addr = 5'd0;
      tick();
      check("rst_rd_rvalid", 96'(rvalid), 96'(0));
      check("rst_rd_rdata", 96'(rdata), 96'(0));
      check("rst_rd_irq", 96'(irq), 96'(0));
      check("rst_rd_out", 96'(out_port), 96'(0));
      reset = 1'b0; sel = 1'b0; rd = 1'b0;
      tick();
      check("rst_rd_rvalid2", 96'(rvalid), 96'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
